// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding,
// word geometry, default memory depth and the load-count clamp helper.
package instr_loader_pkg;

    localparam int BYTES_PER_WORD    = 4;
    localparam int WORD_W            = 32;
    localparam int DEFAULT_MEM_WORDS = 65;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Requested word count limited to the physical depth of the memory.
    function automatic logic [15:0] clamp_words(input logic [15:0] req,
                                                input logic [15:0] limit);
        if (req > limit) begin
            return limit;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte packer: shifts accepted bytes into a 24-bit assembly
// register and presents the completed word together with the fourth byte,
// so the owner can capture it on the same edge as the final handshake.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              fire_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [23:0] shift_q;
    logic [23:0] shift_d;

    // Completed word is the three buffered bytes followed by the byte in flight.
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = fire_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    // Next assembly state: clear on a new load, shift on each accepted byte.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (fire_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end else begin
            cnt_d   = cnt_q;
            shift_d = shift_q;
        end
    end

    // Assembly register and byte counter; reset discards any partial word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts a byte stream, packs it into 32-bit
// big-endian words and writes them to consecutive word addresses while
// holding the CPU off. Every output is a flop.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic [15:0]       num_words_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [WORD_W-1:0] wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic [15:0]       words_o
);

    localparam logic [15:0] MEM_WORDS_W = 16'(MEM_WORDS);

    state_e              state_q;
    state_e              state_d;
    logic [15:0]         target_q;
    logic [15:0]         target_d;
    logic [15:0]         words_q;
    logic [15:0]         words_d;
    logic                we_q;
    logic                we_d;
    logic [ADDR_W-1:0]   waddr_q;
    logic [ADDR_W-1:0]   waddr_d;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   wdata_d;
    logic                ready_q;
    logic                ready_d;
    logic                hold_q;
    logic                hold_d;
    logic                done_q;
    logic                done_d;

    logic                fire_s;
    logic                accept_s;
    logic [15:0]         req_target_s;
    logic [WORD_W-1:0]   packed_word_s;
    logic                word_valid_s;

    // A byte transfers only while the registered ready is high (LOAD only).
    assign fire_s       = byte_valid_i && ready_q;
    assign accept_s     = load_start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign req_target_s = clamp_words(num_words_i, MEM_WORDS_W);

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (accept_s),
        .fire_i       (fire_s),
        .byte_i       (byte_i),
        .word_o       (packed_word_s),
        .word_valid_o (word_valid_s)
    );

    // Next-state logic; a zero-length load goes straight to DONE.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start_i) begin
                    target_d = req_target_s;
                    if (req_target_s == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (word_valid_s && ((words_q + 16'd1) == target_q)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write port: capture the finished word one cycle after its last byte,
    // bump the word count in that same cycle, hold address/data otherwise.
    always_comb begin
        we_d    = word_valid_s;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        words_d = words_q;
        if (accept_s) begin
            words_d = 16'd0;
        end else if (word_valid_s) begin
            waddr_d = ADDR_W'(words_q) * ADDR_W'(BYTES_PER_WORD);
            wdata_d = packed_word_s;
            words_d = words_q + 16'd1;
        end else begin
            words_d = words_q;
        end
    end

    // Status flags registered from the next state so they switch with it.
    always_comb begin
        ready_d = (state_d == ST_LOAD);
        hold_d  = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
    end

    // State, counters and all output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            target_q <= 16'd0;
            words_q  <= 16'd0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            words_q  <= words_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign words_o      = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and randomized loads checked every
// cycle against a transaction-level model of the loader's externally
// visible behaviour.
module tb_instr_mem_loader;

    localparam int MEMW = 65;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [15:0] num_words;
    logic [7:0]  byte_d;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic [15:0] words;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int          m_target;
    int          m_bytes;
    int          m_writes;
    logic        m_busy;
    logic        m_done;
    logic        we_due;
    logic [7:0]  byteq[$];
    wr_t         expq[$];
    wr_t         wlog[$];

    instr_mem_loader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_start_i (load_start),
        .num_words_i  (num_words),
        .byte_i       (byte_d),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .cpu_hold_o   (cpu_hold),
        .done_o       (done),
        .words_o      (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle reference model: outputs checked mid-cycle, then the model
    // advances according to what the edge ahead will see.
    always @(negedge clk) begin
        logic busy_now;
        logic m_ready;
        wr_t  e;
        wr_t  w;
        int   t;
        if (rst) begin
            m_target = 0; m_bytes = 0; m_writes = 0;
            m_busy = 1'b0; m_done = 1'b0; we_due = 1'b0;
            byteq.delete(); expq.delete();
        end else begin
            busy_now = m_busy;
            check_eq("we_timing", 32'(we), 32'(we_due));
            we_due = 1'b0;
            if (we) begin
                m_writes++;
                w.addr = waddr; w.data = wdata;
                wlog.push_back(w);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check_eq("waddr", waddr, e.addr);
                    check_eq("wdata", wdata, e.data);
                end else begin
                    check_eq("we_extra", 32'(we), 32'd0);
                end
                if (m_writes == m_target) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            check_eq("words", 32'(words), 32'(m_writes));
            m_ready = busy_now && (m_bytes < 4 * m_target);
            check_eq("ready", 32'(byte_ready), 32'(m_ready));
            check_eq("hold", 32'(cpu_hold), 32'(busy_now));
            check_eq("done", 32'(done), 32'(busy_now ? 1'b0 : m_done));
            if (byte_valid && m_ready) begin
                m_bytes++;
                byteq.push_back(byte_d);
                if (byteq.size() == 4) begin
                    e.addr = 32'(4 * (m_bytes / 4 - 1));
                    e.data = {byteq[0], byteq[1], byteq[2], byteq[3]};
                    expq.push_back(e);
                    byteq.delete();
                    we_due = 1'b1;
                end
            end
            if (load_start && !busy_now) begin
                t = (int'(num_words) > MEMW) ? MEMW : int'(num_words);
                m_target = t; m_bytes = 0; m_writes = 0;
                byteq.delete(); expq.delete();
                if (t == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_done = 1'b0;
                end
            end
        end
    end

    task automatic start_load(input logic [15:0] n);
        @(posedge clk); #1;
        load_start = 1'b1;
        num_words  = n;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic got;
        byte_d     = b;
        byte_valid = 1'b1;
        got        = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = byte_ready;
            @(posedge clk); #1;
        end
        check_eq("hs_timeout", 32'(got), 32'd1);
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31 - 8*i -: 8], gap);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
        end
        check_eq("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check_eq({tag, "_we"},    32'(we),         32'd0);
        check_eq({tag, "_waddr"}, waddr,           32'd0);
        check_eq({tag, "_wdata"}, wdata,           32'd0);
        check_eq({tag, "_hold"},  32'(cpu_hold),   32'd0);
        check_eq({tag, "_done"},  32'(done),       32'd0);
        check_eq({tag, "_words"}, 32'(words),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; load_start = 1'b0; num_words = 16'd0;
        byte_d = 8'd0; byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // zero-length load: done next cycle, nothing written
        wlog.delete();
        start_load(16'd0);
        check_eq("zero_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("zero_writes", 32'(wlog.size()), 32'd0);

        // two words back-to-back, then with three idle cycles between bytes
        for (int g = 0; g < 2; g++) begin
            wlog.delete();
            start_load(16'd2);
            send_word(32'h20010005, (g == 0) ? 0 : 3);
            send_word(32'h00000000, (g == 0) ? 0 : 3);
            byte_valid = 1'b0;
            wait_done();
            check_eq("two_count", 32'(wlog.size()), 32'd2);
            if (wlog.size() == 2) begin
                check_eq("two_a0", wlog[0].addr, 32'd0);
                check_eq("two_d0", wlog[0].data, 32'h20010005);
                check_eq("two_a1", wlog[1].addr, 32'd4);
                check_eq("two_d1", wlog[1].data, 32'h00000000);
            end
            check_eq("two_words", 32'(words), 32'd2);
        end

        // randomized short loads with random gaps
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            wlog.delete();
            start_load(16'(n));
            for (int k = 0; k < n; k++) begin
                send_word($urandom, $urandom_range(0, 2));
            end
            byte_valid = 1'b0;
            wait_done();
            check_eq("rnd_count", 32'(wlog.size()), 32'(n));
            check_eq("rnd_words", 32'(words), 32'(n));
        end

        // oversize request clamps to memory depth
        wlog.delete();
        start_load(16'd100);
        for (int k = 0; k < MEMW; k++) begin
            send_word($urandom, $urandom_range(0, 1));
        end
        byte_d = 8'hA5; byte_valid = 1'b1;
        wait_done();
        repeat (8) @(negedge clk);
        byte_valid = 1'b0;
        check_eq("clamp_count", 32'(wlog.size()), 32'd65);
        if (wlog.size() == 65) begin
            check_eq("clamp_last_addr", wlog[64].addr, 32'd256);
        end
        check_eq("clamp_bytes", 32'(m_bytes), 32'd260);
        check_eq("clamp_words", 32'(words), 32'd65);

        // asynchronous reset in the middle of a word
        start_load(16'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        byte_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wlog.delete();
        start_load(16'd1);
        send_word(32'hDEADBEEF, 0);
        byte_valid = 1'b0;
        wait_done();
        check_eq("post_rst_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            check_eq("post_rst_addr", wlog[0].addr, 32'd0);
            check_eq("post_rst_data", wlog[0].data, 32'hDEADBEEF);
        end

        // start pulse during LOAD is ignored
        wlog.delete();
        start_load(16'd3);
        send_word($urandom, 1);
        byte_valid = 1'b0;
        start_load(16'd1);
        send_word($urandom, 0);
        send_word($urandom, 2);
        byte_valid = 1'b0;
        wait_done();
        check_eq("ignore_count", 32'(wlog.size()), 32'd3);
        check_eq("ignore_words", 32'(words), 32'd3);

        // reload from DONE restarts at address 0
        wlog.delete();
        start_load(16'd2);
        check_eq("reload_done_drop", 32'(done), 32'd0);
        send_word($urandom, 0);
        send_word($urandom, 1);
        byte_valid = 1'b0;
        wait_done();
        check_eq("reload_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check_eq("reload_addr0", wlog[0].addr, 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
